ibex_multdiv_sched: RTL and testbench
=====================================

# ibex_multdiv_sched

Two-requester scheduler that shares a single `ibex_multdiv_fast` engine between independent issue ports. It arbitrates round-robin and latches the granted operation. It sequences the engine's enable/select/ready handshake and owns the engine's intermediate-value (`imd_val`) registers. It also holds each result until the owning requester accepts it, with a watchdog that terminates hung operations.

## Interface
Parameters:
- `MaxCycles`, default 64: watchdog limit, in BUSY cycles, before forced error completion (must be ≥ 40 for RV32MFast).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i[2]` in 1 each: request valid per requester; held until `req_ready_o`.
- `req_ready_o[2]` out 1 each: request accepted this cycle.
- `req_op_i[2]` in `md_op_e`: MD_OP_MULL/MULH/DIV/REM.
- `req_signed_i[2]` in 2: signed_mode {b, a}.
- `req_a_i[2]`, `req_b_i[2]` in 32: operands.
- `rsp_valid_o[2]` out 1 each: result available for requester n.
- `rsp_ready_i[2]` in 1 each: requester accepts result.
- `rsp_result_o` out 32: result, shared bus, valid with any `rsp_valid_o`.
- `rsp_err_o` out 1: watchdog expiry flag, valid with `rsp_valid_o`.
- `md_mult_en_o`, `md_div_en_o`, `md_mult_sel_o`, `md_div_sel_o` out 1: engine enables/selects.
- `md_operator_o` out `md_op_e`; `md_signed_mode_o` out 2; `md_op_a_o`, `md_op_b_o` out 32: latched operation to engine.
- `md_ready_id_o` out 1: to engine `multdiv_ready_id_i`.
- `md_valid_i` in 1; `md_result_i` in 32: engine completion.
- `md_imd_val_d_i[2]` in 34; `md_imd_val_we_i` in 2: engine intermediate writes.
- `md_imd_val_q_o[2]` out 34: intermediate register contents to engine.

## Operation
- Mult class is MULL/MULH; div class is DIV/REM. `*_en_o` and `*_sel_o` are asserted together for the class in BUSY only.
- IDLE
  - `req_ready_o[g]` is asserted combinationally for grant g.
  - Grant priority: the requester other than `last_q`; if it is not valid, the only valid requester.
  - On grant: latch op, signed, a, b and `id_q`=g; set `last_q`=g; clear both imd registers to 0; clear the watchdog counter; go to BUSY.
- BUSY
  - Drive the latched operation and `md_ready_id_o`=1. Increment the counter each cycle.
  - Honour `md_imd_val_we_i` per bit.
  - On `md_valid_i`: capture `md_result_i` and set err=0; go to RESP. The enables drop in the next cycle.
  - If the counter reaches `MaxCycles`−1 with no valid: capture 0 and set err=1; go to RESP.
  - When `md_valid_i` and expiry fall in the same cycle, valid wins (err=0).
- RESP
  - `rsp_valid_o[id_q]`=1 with the result held stable. All `req_ready_o`=0.
  - On `rsp_ready_i[id_q]`, go to IDLE. No grant is made in the same cycle.
- Requests arriving in BUSY/RESP wait; ready stays 0. `rsp_ready_i` of the non-owner is ignored.
- Divide-by-zero and overflow semantics are the engine's; the result is passed through unmodified.

## Timing
- All outputs reset to 0:
  - state=IDLE, `last_q`=1 (so requester 0 wins the first tie);
  - imd registers 0, counter 0, result/err 0.
- Reset asserted mid-operation aborts immediately and asynchronously. No response is ever issued for the aborted request.
- Latency, accept to `rsp_valid_o`: 1 + engine cycles. The first BUSY cycle is the cycle after the grant.
- Single-cycle MULL in RV32MSingleCycle: BUSY lasts until `md_valid_i`, then `rsp_valid_o` is high on the following cycle.
- Minimum request-to-request spacing is 3 cycles (IDLE, BUSY, RESP).
- Imd register writes take effect on the next edge. `md_imd_val_q_o` is the registered value.

## Structure
- `mdsched_state_e` (IDLE/BUSY/RESP) belongs in `ibex_pkg`, next to `md_op_e`.
- One sub-module, `ibex_multdiv_rr_arb`: a 2-way round-robin grant, combinational from valids and `last_q`.
- Imd registers, FSM, watchdog and response register live in the top.

## Test plan
- Unsigned MULL: req0 a=10, b=3, signed=00 → `rsp_valid_o[0]` with result 30; err=0; `req_ready_o[0]` pulses exactly once.
- Signed DIV: req1 a=−50, b=7, signed=11 → result 0xFFFFFFF9 (−7) on `rsp_valid_o[1]`. Imd registers are written during BUSY.
- Divide by zero: unsigned DIV 42/0 → 0xFFFFFFFF; REM 42/0 → 42.
- Contention: both requesters valid continuously with MULL 1000×−2 and MULL −12×5 → grants alternate 0,1,0,1 from reset, with results −2000 and −60.
- Backpressure and watchdog:
  - Hold `rsp_ready_i` low for 5 cycles → result is stable and no new grant occurs.
  - Stub engine that never asserts valid → `rsp_err_o`=1 with result 0 after `MaxCycles` BUSY cycles.
- Reset pulse in mid-division → all outputs are 0 immediately. A new request after reset completes correctly (147/147 → 1).

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared multiplier/divider types: engine operation encoding, scheduler states
// and the latched request payload.
package ibex_pkg;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_IMD_W  = 34;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } mdsched_state_e;

    typedef struct packed {
        md_op_e                 op;
        logic [1:0]             sgn;
        logic [MD_DATA_W-1:0]   a;
        logic [MD_DATA_W-1:0]   b;
    } md_req_t;

    // MULL/MULH go to the multiplier, DIV/REM to the divider.
    function automatic logic md_is_mult(input md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_multdiv_rr_arb.sv
// Two-way round-robin grant: the requester that was not served last wins a tie.
module ibex_multdiv_rr_arb (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       gnt_valid_c,
    output logic       gnt_id_c
);

    logic pref;

    always_comb begin
        pref        = ~last;
        gnt_valid_c = |valid;
        gnt_id_c    = valid[pref] ? pref : last;
    end

endmodule

// File: rtl/ibex_multdiv_sched.sv
// Shares one multiplier/divider engine between two issue ports: arbitration,
// engine handshake, intermediate-value registers, watchdog and result hold.
module ibex_multdiv_sched
    import ibex_pkg::*;
#(
    parameter int unsigned MaxCycles = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  md_op_e               req_op_i     [2],
    input  logic [1:0]           req_signed_i [2],
    input  logic [MD_DATA_W-1:0] req_a_i      [2],
    input  logic [MD_DATA_W-1:0] req_b_i      [2],

    output logic [1:0]           rsp_valid_o,
    input  logic [1:0]           rsp_ready_i,
    output logic [MD_DATA_W-1:0] rsp_result_o,
    output logic                 rsp_err_o,

    output logic                 md_mult_en_o,
    output logic                 md_div_en_o,
    output logic                 md_mult_sel_o,
    output logic                 md_div_sel_o,
    output md_op_e               md_operator_o,
    output logic [1:0]           md_signed_mode_o,
    output logic [MD_DATA_W-1:0] md_op_a_o,
    output logic [MD_DATA_W-1:0] md_op_b_o,
    output logic                 md_ready_id_o,
    input  logic                 md_valid_i,
    input  logic [MD_DATA_W-1:0] md_result_i,
    input  logic [MD_IMD_W-1:0]  md_imd_val_d_i [2],
    input  logic [1:0]           md_imd_val_we_i,
    output logic [MD_IMD_W-1:0]  md_imd_val_q_o [2]
);

    localparam int unsigned CntW = $clog2(MaxCycles) + 1;

    mdsched_state_e       state_q, state_d;
    md_req_t              op_q;
    logic                 id_q, last_q;
    logic [MD_IMD_W-1:0]  imd_q [2];
    logic [CntW-1:0]      cnt_q;
    logic [MD_DATA_W-1:0] result_q;
    logic                 err_q;
    logic                 gnt_valid, gnt_id;
    logic                 expire, is_mult;

    ibex_multdiv_rr_arb u_arb (
        .valid       (req_valid_i),
        .last        (last_q),
        .gnt_valid_c (gnt_valid),
        .gnt_id_c    (gnt_id)
    );

    assign expire  = (cnt_q == CntW'(MaxCycles - 1));
    assign is_mult = md_is_mult(op_q.op);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; engine valid takes precedence over watchdog expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_valid) state_d = BUSY;
            BUSY:    if (md_valid_i || expire) state_d = RESP;
            RESP:    if (rsp_ready_i[id_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready_o   = 2'b00;
        rsp_valid_o   = 2'b00;
        md_mult_en_o  = 1'b0;
        md_div_en_o   = 1'b0;
        md_mult_sel_o = 1'b0;
        md_div_sel_o  = 1'b0;
        md_ready_id_o = 1'b0;
        unique case (state_q)
            IDLE: req_ready_o[gnt_id] = gnt_valid;
            BUSY: begin
                md_ready_id_o = 1'b1;
                md_mult_en_o  = is_mult;
                md_mult_sel_o = is_mult;
                md_div_en_o   = ~is_mult;
                md_div_sel_o  = ~is_mult;
            end
            RESP: rsp_valid_o[id_q] = 1'b1;
            default: ;
        endcase
    end

    // Operation latch, intermediate registers, watchdog and response capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            imd_q[0] <= '0;
            imd_q[1] <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        op_q.op  <= req_op_i[gnt_id];
                        op_q.sgn <= req_signed_i[gnt_id];
                        op_q.a   <= req_a_i[gnt_id];
                        op_q.b   <= req_b_i[gnt_id];
                        id_q     <= gnt_id;
                        last_q   <= gnt_id;
                        imd_q[0] <= '0;
                        imd_q[1] <= '0;
                        cnt_q    <= '0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CntW'(1);
                    for (int i = 0; i < 2; i++) begin
                        if (md_imd_val_we_i[i]) imd_q[i] <= md_imd_val_d_i[i];
                    end
                    if (md_valid_i) begin
                        result_q <= md_result_i;
                        err_q    <= 1'b0;
                    end else if (expire) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_operator_o     = op_q.op;
    assign md_signed_mode_o  = op_q.sgn;
    assign md_op_a_o         = op_q.a;
    assign md_op_b_o         = op_q.b;
    assign md_imd_val_q_o[0] = imd_q[0];
    assign md_imd_val_q_o[1] = imd_q[1];
    assign rsp_result_o      = result_q;
    assign rsp_err_o         = err_q;

endmodule

// File: tb/tb_ibex_multdiv_sched.sv
// Directed bench for ibex_multdiv_sched with a behavioural engine stub
// (1-cycle multiply, configurable-latency divide).
module tb_ibex_multdiv_sched;
    import ibex_pkg::*;

    localparam int unsigned MUL_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    md_op_e      req_op_i     [2];
    logic [1:0]  req_signed_i [2];
    logic [31:0] req_a_i      [2];
    logic [31:0] req_b_i      [2];
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_err_o;
    logic        md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
    md_op_e      md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o, md_op_b_o;
    logic        md_ready_id_o;
    logic        md_valid_i = 1'b0;
    logic [31:0] md_result_i = '0;
    logic [33:0] md_imd_val_d_i [2] = '{34'h0, 34'h0};
    logic [1:0]  md_imd_val_we_i = 2'b00;
    logic [33:0] md_imd_val_q_o [2];

    int n_checks = 0;
    int n_errors = 0;
    bit eng_on   = 1'b1;
    int div_lat  = 4;
    int eng_cnt  = 0;

    always #5 clk = ~clk;

    ibex_multdiv_sched dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_signed_i     (req_signed_i),
        .req_a_i          (req_a_i),
        .req_b_i          (req_b_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_result_o     (rsp_result_o),
        .rsp_err_o        (rsp_err_o),
        .md_mult_en_o     (md_mult_en_o),
        .md_div_en_o      (md_div_en_o),
        .md_mult_sel_o    (md_mult_sel_o),
        .md_div_sel_o     (md_div_sel_o),
        .md_operator_o    (md_operator_o),
        .md_signed_mode_o (md_signed_mode_o),
        .md_op_a_o        (md_op_a_o),
        .md_op_b_o        (md_op_b_o),
        .md_ready_id_o    (md_ready_id_o),
        .md_valid_i       (md_valid_i),
        .md_result_i      (md_result_i),
        .md_imd_val_d_i   (md_imd_val_d_i),
        .md_imd_val_we_i  (md_imd_val_we_i),
        .md_imd_val_q_o   (md_imd_val_q_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] eng_calc(input md_op_e op, input logic [1:0] sg,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa, sb;
        logic signed [65:0] p;
        logic               sdiv;
        sa   = {sg[0] & a[31], a};
        sb   = {sg[1] & b[31], b};
        p    = sa * sb;
        sdiv = (sg == 2'b11);
        case (op)
            MD_OP_MULL: return p[31:0];
            MD_OP_MULH: return p[63:32];
            MD_OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                if (sdiv) return 32'($signed(a) / $signed(b));
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                if (sdiv) return 32'($signed(a) % $signed(b));
                return a % b;
            end
        endcase
    endfunction

    // Engine stub: writes imd 0 then imd 1 early in a divide, then reports the result
    always @(negedge clk) begin
        if (eng_on && (md_mult_en_o || md_div_en_o)) begin
            eng_cnt         = eng_cnt + 1;
            md_imd_val_we_i = 2'b00;
            if (md_div_en_o && eng_cnt == 1) begin
                md_imd_val_we_i   = 2'b01;
                md_imd_val_d_i[0] = 34'h2_DEAD_BEEF;
                md_imd_val_d_i[1] = 34'h3_FFFF_FFFF;
            end
            if (md_div_en_o && eng_cnt == 2) begin
                md_imd_val_we_i   = 2'b10;
                md_imd_val_d_i[0] = 34'h0_0BAD_0BAD;
                md_imd_val_d_i[1] = 34'h1_0000_0005;
            end
            if (eng_cnt == (md_mult_en_o ? MUL_LAT : div_lat)) begin
                md_valid_i  = 1'b1;
                md_result_i = eng_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
            end else begin
                md_valid_i = 1'b0;
            end
        end else begin
            eng_cnt         = 0;
            md_valid_i      = 1'b0;
            md_imd_val_we_i = 2'b00;
        end
    end

    task automatic do_req(input string tag, input int id, input md_op_e op, input logic [1:0] sg,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat, input int bp);
        int k;
        int pulses;
        int other;
        other = 1 - id;
        req_op_i[id]     = op;
        req_signed_i[id] = sg;
        req_a_i[id]      = a;
        req_b_i[id]      = b;
        req_valid_i[id]  = 1'b1;
        #1;
        k = 0;
        while (!req_ready_o[id] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_accept"}, 64'(req_ready_o[id]), 64'd1);
        if (!req_ready_o[id]) begin
            req_valid_i[id] = 1'b0;
            return;
        end
        pulses = 1;
        @(posedge clk); #1;
        req_valid_i[id] = 1'b0;
        check({tag, "_imd0_clr"}, 64'(md_imd_val_q_o[0]), 64'd0);
        check({tag, "_imd1_clr"}, 64'(md_imd_val_q_o[1]), 64'd0);
        check({tag, "_op_a"}, 64'(md_op_a_o), 64'(a));
        check({tag, "_op_b"}, 64'(md_op_b_o), 64'(b));
        check({tag, "_ready_id"}, 64'(md_ready_id_o), 64'd1);
        k = 0;
        while (!rsp_valid_o[id] && k < 200) begin
            if (req_ready_o[id]) pulses++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(2'b01 << id));
        check({tag, "_result"}, 64'(rsp_result_o), 64'(exp_res));
        check({tag, "_err"}, 64'(rsp_err_o), 64'(exp_err));
        check({tag, "_en_off"}, 64'({md_mult_en_o, md_div_en_o}), 64'd0);
        if (bp > 0) begin
            req_op_i[other]    = MD_OP_MULL;
            req_signed_i[other] = 2'b00;
            req_a_i[other]     = 32'd1;
            req_b_i[other]     = 32'd1;
            req_valid_i[other] = 1'b1;
            rsp_ready_i[other] = 1'b1;
            for (int j = 0; j < bp; j++) begin
                @(posedge clk); #1;
                check({tag, "_bp_result"}, 64'(rsp_result_o), 64'(exp_res));
                check({tag, "_bp_valid"}, 64'(rsp_valid_o), 64'(2'b01 << id));
                check({tag, "_bp_ready"}, 64'(req_ready_o), 64'd0);
            end
            req_valid_i[other] = 1'b0;
            rsp_ready_i[other] = 1'b0;
        end
        check({tag, "_ready_pulses"}, 64'(pulses), 64'd1);
        rsp_ready_i[id] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i[id] = 1'b0;
        check({tag, "_rsp_done"}, 64'(rsp_valid_o), 64'd0);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int grants[4];
        int ng, nr, k;
        bit drop;
        logic [31:0] exp_c [2];

        rst_ni      = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_op_i[i]     = MD_OP_MULL;
            req_signed_i[i] = 2'b00;
            req_a_i[i]      = '0;
            req_b_i[i]      = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_en", 64'({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o}), 64'd0);
        check("rst_ready_id", 64'(md_ready_id_o), 64'd0);
        check("rst_result", 64'({rsp_err_o, rsp_result_o}), 64'd0);
        check("rst_op", 64'({md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o[27:0]}), 64'd0);
        check("rst_imd", 64'(md_imd_val_q_o[0] | md_imd_val_q_o[1]), 64'd0);
        rst_ni = 1'b1;

        // Contention from reset: both hold valid, grants must alternate starting at 0
        req_op_i[0] = MD_OP_MULL; req_a_i[0] = 32'd1000;         req_b_i[0] = 32'hFFFF_FFFE;
        req_op_i[1] = MD_OP_MULL; req_a_i[1] = 32'hFFFF_FFF4;    req_b_i[1] = 32'd5;
        req_signed_i[0] = 2'b11;  req_signed_i[1] = 2'b11;
        exp_c[0] = 32'hFFFF_F830;
        exp_c[1] = 32'hFFFF_FFC4;
        req_valid_i = 2'b11;
        ng = 0; nr = 0; drop = 1'b0;
        for (int cyc = 0; cyc < 200 && nr < 4; cyc++) begin
            rsp_ready_i = 2'b00;
            if (drop) req_valid_i = 2'b00;
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_ready_o[i] && ng < 4) begin
                    grants[ng] = i;
                    ng++;
                    if (ng == 4) drop = 1'b1;
                end
                if (rsp_valid_o[i]) begin
                    check($sformatf("cont_result%0d", i), 64'(rsp_result_o), 64'(exp_c[i]));
                    rsp_ready_i[i] = 1'b1;
                    nr++;
                end
            end
            @(posedge clk); #1;
        end
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b00;
        check("cont_rsp_count", 64'(nr), 64'd4);
        check("cont_gnt_count", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) check($sformatf("cont_gnt%0d", i), 64'(grants[i]), 64'(i % 2));
        end
        repeat (2) @(posedge clk);
        #1;

        do_req("mull", 0, MD_OP_MULL, 2'b00, 32'd10, 32'd3, 32'd30, 1'b0, 1, 0);
        do_req("sdiv", 1, MD_OP_DIV, 2'b11, 32'hFFFF_FFCE, 32'd7, 32'hFFFF_FFF9, 1'b0, 4, 0);
        check("sdiv_imd0", 64'(md_imd_val_q_o[0]), 64'h2_DEAD_BEEF);
        check("sdiv_imd1", 64'(md_imd_val_q_o[1]), 64'h1_0000_0005);
        do_req("div0", 0, MD_OP_DIV, 2'b00, 32'd42, 32'd0, 32'hFFFF_FFFF, 1'b0, 4, 0);
        do_req("rem0", 1, MD_OP_REM, 2'b00, 32'd42, 32'd0, 32'd42, 1'b0, 4, 0);
        do_req("bp", 0, MD_OP_MULL, 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 1, 5);

        // Watchdog: engine never answers, forced error after MaxCycles BUSY cycles
        eng_on = 1'b0;
        do_req("wdog", 1, MD_OP_DIV, 2'b00, 32'd9, 32'd3, 32'd0, 1'b1, 64, 0);
        eng_on = 1'b1;

        // Reset in mid-division aborts without any response
        div_lat = 10;
        req_op_i[0] = MD_OP_DIV; req_signed_i[0] = 2'b00;
        req_a_i[0] = 32'd100;    req_b_i[0] = 32'd3;
        req_valid_i[0] = 1'b1;
        #1;
        check("abort_accept", 64'(req_ready_o[0]), 64'd1);
        @(posedge clk); #1;
        req_valid_i[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", 64'(md_div_en_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("abort_en", 64'({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o}), 64'd0);
        check("abort_rsp", 64'({rsp_valid_o, req_ready_o, rsp_err_o}), 64'd0);
        check("abort_op", 64'({md_operator_o, md_signed_mode_o, md_op_a_o}), 64'd0);
        check("abort_imd", 64'(md_imd_val_q_o[0] | md_imd_val_q_o[1]), 64'd0);
        check("abort_result", 64'(rsp_result_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_o != 2'b00) k++;
        end
        check("abort_no_rsp", 64'(k), 64'd0);
        div_lat = 4;
        do_req("post_rst", 0, MD_OP_DIV, 2'b00, 32'd147, 32'd147, 32'd1, 1'b0, 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
